ro_enc_ctrl: RTL and testbench

Front-panel rotary encoder controller: debounces N_ENC quadrature encoders, decodes full-detent steps (rest state 00 to 11 or 11 to 00), accumulates a signed step count per encoder, and schedules pending counts to the PS one event at a time. It uses a round-robin arbiter with a valid/ack handshake and a level interrupt. It replaces per-encoder interrupt FSMs that required a PS clear between single steps and lost steps during fast rotation.

---
 rtl/ro_enc_pkg.sv | 32 +++
 rtl/ro_enc_detent.sv | 106 ++++++++++
 rtl/ro_enc_ctrl.sv | 123 ++++++++++++
 tb/tb_ro_enc_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_enc_pkg.sv
// Shared types and helpers for the rotary encoder controller.
package ro_enc_pkg;

  typedef enum logic [1:0] {
    DET_WAIT,
    DET_REST,
    DET_MOVE_CW,
    DET_MOVE_CCW
  } det_state_t;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_PRESENT,
    SCH_GAP
  } sch_state_t;

  localparam logic [1:0] REST_LO = 2'b00;
  localparam logic [1:0] REST_HI = 2'b11;

  localparam int SAT_W = 32;

  // Clamp to the symmetric range +/-(2^(cnt_w-1)-1) so a count can always be negated.
  function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] val,
                                                       input int cnt_w);
    logic signed [SAT_W-1:0] lim;
    lim = (32'sd1 <<< (cnt_w - 1)) - 32'sd1;
    if (val > lim) return lim;
    else if (val < -lim) return -lim;
    else return val;
  endfunction

endpackage

// File: rtl/ro_enc_detent.sv
// One encoder: 2-FF sync, per-channel debounce, full-detent decode into step pulses.
//   state        | meaning
//   DET_WAIT     | after reset, waiting for a rest code (00/11)
//   DET_REST     | resting on code in 'rest'
//   DET_MOVE_CW  | A left rest first, heading clockwise
//   DET_MOVE_CCW | B left rest first, heading counter-clockwise
module ro_enc_detent
  import ro_enc_pkg::*;
#(
  parameter int DEB_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enc_a,
  input  logic enc_b,
  output logic step_cw,
  output logic step_ccw
);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEB_CYC - 1);

  logic [1:0] meta;
  logic [1:0] synced;
  logic [1:0] deb;
  logic [DEB_W-1:0] deb_cnt [2];

  det_state_t state, state_nx;
  logic [1:0] rest, rest_nx;
  logic cw_nx, ccw_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= {enc_a, enc_b};
      synced <= meta;
    end
  end

  // Down-counter reloads whenever the channel agrees; DEB_CYC differing samples commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int c = 0; c < 2; c++) deb_cnt[c] <= DEB_LOAD;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (synced[c] == deb[c]) begin
          deb_cnt[c] <= DEB_LOAD;
        end else if (deb_cnt[c] == '0) begin
          deb[c]     <= synced[c];
          deb_cnt[c] <= DEB_LOAD;
        end else begin
          deb_cnt[c] <= deb_cnt[c] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DET_WAIT;
      rest     <= REST_LO;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
    end else begin
      state    <= state_nx;
      rest     <= rest_nx;
      step_cw  <= cw_nx;
      step_ccw <= ccw_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rest_nx  = rest;
    cw_nx    = 1'b0;
    ccw_nx   = 1'b0;
    case (state)
      DET_WAIT: begin
        if (deb == REST_LO || deb == REST_HI) begin
          state_nx = DET_REST;
          rest_nx  = deb;
        end
      end
      DET_REST: begin
        if (deb == ~rest) rest_nx = deb;
        else if (deb[1] != rest[1]) state_nx = DET_MOVE_CW;
        else if (deb[0] != rest[0]) state_nx = DET_MOVE_CCW;
      end
      DET_MOVE_CW, DET_MOVE_CCW: begin
        if (deb == ~rest) begin
          state_nx = DET_REST;
          rest_nx  = deb;
          cw_nx    = (state == DET_MOVE_CW);
          ccw_nx   = (state == DET_MOVE_CCW);
        end else if (deb == rest) begin
          state_nx = DET_REST;
        end
      end
      default: state_nx = DET_WAIT;
    endcase
  end

endmodule

// File: rtl/ro_enc_ctrl.sv
// Encoder controller top: per-encoder step accumulators and a round-robin event scheduler.
//   state       | meaning
//   SCH_IDLE    | searching from last_idx+1 for a nonzero accumulator
//   SCH_PRESENT | event held on o_evt_*, waiting for ack
//   SCH_GAP     | one quiet cycle so every event gives a fresh intr edge
module ro_enc_ctrl
  import ro_enc_pkg::*;
#(
  parameter int N_ENC   = 4,
  parameter int DEB_CYC = 1000,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = (N_ENC > 1) ? $clog2(N_ENC) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_ENC-1:0]        i_enc_a,
  input  logic [N_ENC-1:0]        i_enc_b,
  input  logic                    i_evt_ack,
  output logic                    o_evt_valid,
  output logic [IDX_W-1:0]        o_evt_idx,
  output logic signed [CNT_W-1:0] o_evt_cnt,
  output logic                    o_intr,
  output logic [N_ENC-1:0]        o_ovf
);

  logic [N_ENC-1:0] step_cw;
  logic [N_ENC-1:0] step_ccw;

  for (genvar g = 0; g < N_ENC; g++) begin : g_enc
    ro_enc_detent #(.DEB_CYC(DEB_CYC)) u_detent (
      .clk     (i_clk),
      .rst     (i_rst),
      .enc_a   (i_enc_a[g]),
      .enc_b   (i_enc_b[g]),
      .step_cw (step_cw[g]),
      .step_ccw(step_ccw[g])
    );
  end

  logic signed [CNT_W-1:0] acc [N_ENC];
  logic signed [SAT_W-1:0] acc_raw [N_ENC];
  logic signed [SAT_W-1:0] acc_sat [N_ENC];

  sch_state_t state, state_nx;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] idx_q;
  logic signed [CNT_W-1:0] cnt_q;
  logic found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic ack_fire;

  assign ack_fire = (state == SCH_PRESENT) && i_evt_ack;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N_ENC; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % N_ENC);
      if (!found && acc[cand] != '0) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // The ack subtracts only what was reported; same-cycle steps still land.
  always_comb begin
    for (int i = 0; i < N_ENC; i++) begin
      acc_raw[i] = SAT_W'(acc[i]);
      if (step_cw[i])  acc_raw[i] = acc_raw[i] + 32'sd1;
      if (step_ccw[i]) acc_raw[i] = acc_raw[i] - 32'sd1;
      if (ack_fire && idx_q == IDX_W'(i)) acc_raw[i] = acc_raw[i] - SAT_W'(cnt_q);
      acc_sat[i] = sat_clip(acc_raw[i], CNT_W);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_ENC; i++) acc[i] <= '0;
      o_ovf <= '0;
    end else begin
      for (int i = 0; i < N_ENC; i++) begin
        acc[i] <= acc_sat[i][CNT_W-1:0];
        if (ack_fire && idx_q == IDX_W'(i)) o_ovf[i] <= 1'b0;
        if (acc_sat[i] != acc_raw[i]) o_ovf[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= SCH_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      last_idx <= IDX_W'(N_ENC - 1);
    end else begin
      state <= state_nx;
      if (state == SCH_IDLE && found) begin
        idx_q <= pick;
        cnt_q <= acc[pick];
      end
      if (ack_fire) last_idx <= idx_q;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      SCH_IDLE:    if (found) state_nx = SCH_PRESENT;
      SCH_PRESENT: if (i_evt_ack) state_nx = SCH_GAP;
      SCH_GAP:     state_nx = SCH_IDLE;
      default:     state_nx = SCH_IDLE;
    endcase
  end

  assign o_evt_valid = (state == SCH_PRESENT);
  assign o_intr      = (state == SCH_PRESENT);
  assign o_evt_idx   = idx_q;
  assign o_evt_cnt   = cnt_q;

endmodule

// File: tb/tb_ro_enc_ctrl.sv
// Directed plus randomized bench for ro_enc_ctrl against a count-level model of detents and events.
module tb_ro_enc_ctrl;
  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int CW_W = 8;
  localparam int IW   = 2;
  localparam int HOLD = 10;
  localparam int LIM  = 127;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] ea = '0;
  logic [N-1:0] eb = '0;
  logic ack = 1'b0;
  logic valid, intr;
  logic [IW-1:0] idx;
  logic signed [CW_W-1:0] cnt;
  logic [N-1:0] ovf;

  always #5 clk = ~clk;

  ro_enc_ctrl #(.N_ENC(N), .DEB_CYC(DEB), .CNT_W(CW_W), .IDX_W(IW)) dut (
    .i_clk(clk), .i_rst(rst), .i_enc_a(ea), .i_enc_b(eb), .i_evt_ack(ack),
    .o_evt_valid(valid), .o_evt_idx(idx), .o_evt_cnt(cnt), .o_intr(intr), .o_ovf(ovf)
  );

  int total = 0;
  int bad = 0;
  int m_acc [N];
  bit m_ovf [N];
  int m_last;
  logic [1:0] m_rest [N];
  int lat_idx, lat_cnt;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [N-1:0] m_ovf_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_last = N - 1;
  endfunction

  function automatic void model_step(input int i, input int d);
    int v;
    v = m_acc[i] + d;
    if (v > LIM) begin v = LIM; m_ovf[i] = 1'b1; end
    if (v < -LIM) begin v = -LIM; m_ovf[i] = 1'b1; end
    m_acc[i] = v;
  endfunction

  function automatic int exp_pick();
    for (int k = 1; k <= N; k++)
      if (m_acc[(m_last + k) % N] != 0) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic void ack_model();
    m_acc[lat_idx] -= lat_cnt;
    m_ovf[lat_idx] = 1'b0;
    m_last = lat_idx;
  endfunction

  // All encoders in mask move in lockstep; cw chooses which channel leaves rest first.
  task automatic move(input logic [N-1:0] mask, input logic [N-1:0] cw, input bit full);
    logic [1:0] code;
    for (int i = 0; i < N; i++) if (mask[i]) begin
      code = m_rest[i] ^ (cw[i] ? 2'b10 : 2'b01);
      ea[i] = code[1];
      eb[i] = code[0];
    end
    idle(HOLD);
    for (int i = 0; i < N; i++) if (mask[i]) begin
      if (full) begin
        m_rest[i] = ~m_rest[i];
        model_step(i, cw[i] ? 1 : -1);
      end
      ea[i] = m_rest[i][1];
      eb[i] = m_rest[i][0];
    end
    idle(HOLD);
  endtask

  task automatic check_event(input string tag);
    int e, n;
    e = exp_pick();
    if (e < 0) e = 0;
    n = 0;
    while (!valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, " valid"}, valid, 1);
    chk({tag, " intr"}, intr, 1);
    chk({tag, " idx"}, idx, e);
    chk({tag, " cnt"}, cnt, m_acc[e]);
    lat_idx = e;
    lat_cnt = m_acc[e];
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ack_model();
    chk({tag, " gap1"}, valid, 0);
    tick();
    chk({tag, " gap2"}, valid, 0);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_pick() >= 0 && guard < 20) begin
      check_event(tag);
      do_ack(tag);
      guard++;
    end
  endtask

  task automatic no_event(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      seen = seen | valid;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rmask, rcw;
    for (int i = 0; i < N; i++) m_rest[i] = 2'b00;
    model_reset();

    idle(3);
    chk("rst valid", valid, 0);
    chk("rst intr", intr, 0);
    chk("rst idx", idx, 0);
    chk("rst cnt", cnt, 0);
    chk("rst ovf", ovf, 0);
    rst = 1'b0;
    idle(5);

    // Single CW detent on enc0; hold it while enc1 does two CCW detents.
    move(4'b0001, 4'b0001, 1'b1);
    check_event("e0_cw");
    move(4'b0010, 4'b0000, 1'b1);
    move(4'b0010, 4'b0000, 1'b1);
    chk("e0 held valid", valid, 1);
    chk("e0 held cnt", cnt, 1);
    do_ack("e0_ack");
    check_event("e1_ccw2");
    do_ack("e1_ack");

    move(4'b0010, 4'b0010, 1'b0);
    no_event("partial", 40);

    ea[2] = 1'b1;
    idle(3);
    ea[2] = 1'b0;
    no_event("glitch", 40);
    chk("ovf quiet", ovf, m_ovf_vec());

    // Make last_idx 0, then enc0 and enc3 pend together.
    move(4'b0001, 4'b0001, 1'b1);
    check_event("pre0");
    do_ack("pre0_ack");
    move(4'b1001, 4'b1001, 1'b1);
    check_event("rr3");
    ea[3] = ~m_rest[3][1];
    eb[3] = m_rest[3][0];
    idle(HOLD);
    m_rest[3] = ~m_rest[3];
    ea[3] = m_rest[3][1];
    eb[3] = m_rest[3][0];
    model_step(3, 1);
    idle(7);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ack_model();
    chk("rr3 ack gap", valid, 0);
    idle(HOLD);
    check_event("rr0");
    do_ack("rr0_ack");
    check_event("rr3_again");
    do_ack("rr3_again_ack");

    // Saturation: enc1 holds the presenter while enc0 accumulates 130 steps.
    move(4'b0010, 4'b0010, 1'b1);
    check_event("blk1");
    repeat (130) move(4'b0001, 4'b0001, 1'b1);
    chk("sat ovf set", ovf, m_ovf_vec());
    chk("blk1 held idx", idx, 1);
    do_ack("blk1_ack");
    check_event("sat0");
    do_ack("sat0_ack");
    chk("sat ovf clr", ovf, m_ovf_vec());

    for (int r = 0; r < 12; r++) begin
      move(N'(1) << $urandom_range(0, N - 1), N'($urandom), 1'b1);
      check_event("rnd_blk");
      repeat ($urandom_range(1, 4)) begin
        rmask = N'($urandom);
        if (rmask == '0) rmask = 4'b0100;
        rcw = N'($urandom);
        move(rmask, rcw, ($urandom_range(0, 3) != 0));
      end
      do_ack("rnd_blk_ack");
      drain("rnd");
    end
    chk("rnd ovf", ovf, m_ovf_vec());

    // Leave enc2 resting at 11, present enc1, then reset mid-event.
    if (m_rest[2] != 2'b11) begin
      move(4'b0100, 4'b0100, 1'b1);
      drain("to11");
    end
    move(4'b0010, 4'b0010, 1'b1);
    check_event("pre_rst");
    rst = 1'b1;
    tick();
    chk("mid rst valid", valid, 0);
    chk("mid rst intr", intr, 0);
    chk("mid rst idx", idx, 0);
    chk("mid rst cnt", cnt, 0);
    chk("mid rst ovf", ovf, 0);
    rst = 1'b0;
    model_reset();
    no_event("post rst rest11", 60);
    move(4'b0100, 4'b0000, 1'b1);
    check_event("post_rst_ccw");
    do_ack("post_rst_ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
